// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit XNOR LFSR (taps 7 and 3, shift-left, feedback into bit 0).
package lfsr_pkg;

    localparam int          LFSR_W = 8;
    localparam int          TAP_HI = 7;
    localparam int          TAP_LO = 3;
    localparam logic [7:0]  LOCKUP = 8'hFF;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Next feedback bit of the XNOR LFSR for the given register contents.
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] sr);
        return ~(sr[TAP_HI] ^ sr[TAP_LO]);
    endfunction

endpackage

// File: rtl/lfsr_predict.sv
// Combinational next-bit predictor for the XNOR LFSR; also flags the all-ones lockup state.
module lfsr_predict
    import lfsr_pkg::*;
(
    input  logic [LFSR_W-1:0] sr,
    output logic              pred,
    output logic              is_lockup
);

    assign pred      = lfsr_fb(sr);
    assign is_lockup = (sr == LOCKUP);

endmodule

// File: rtl/lfsr_seq_checker.sv
// PRBS receive checker: self-synchronises onto the LFSR bitstream, declares lock,
// then flywheels on its own prediction and counts bit errors.
//
//  state  | meaning
//  FILL   | shifting the first 8 received bits into the shadow register
//  VERIFY | self-syncing on received data, counting consecutive correct predictions
//  LOCKED | flywheel on own prediction, flag/count mismatches, drop lock after a burst
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       state
);

    localparam int CNT_MAX = (LOCK_COUNT > LOSS_THRESH) ? LOCK_COUNT : LOSS_THRESH;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = $clog2(LFSR_W);

    state_t              state_q;
    logic [LFSR_W-1:0]   sr;
    logic [FW-1:0]       fill_cnt;
    logic [CW-1:0]       good;
    logic [CW-1:0]       bad;
    logic                pred;
    logic                is_lockup;
    logic                match;
    logic                err_hit;

    lfsr_predict u_predict (
        .sr        (sr),
        .pred      (pred),
        .is_lockup (is_lockup)
    );

    // The lockup state predicts a 1 forever, so it must never be trusted as a match.
    assign match   = (in_bit == pred) && !is_lockup;
    assign err_hit = in_valid && (state_q == LOCKED) && !match;
    assign state   = state_q;

    // FSM, shadow register, run-length counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FILL;
            sr        <= '0;
            fill_cnt  <= '0;
            good      <= '0;
            bad       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= err_hit;

            // Clear wins over a coincident error; the error still pulses.
            if (clear_cnt)
                err_count <= '0;
            else if (err_hit && (err_count != {ERR_W{1'b1}}))
                err_count <= err_count + ERR_W'(1);

            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        sr <= {sr[LFSR_W-2:0], in_bit};
                        if (fill_cnt == FW'(LFSR_W - 1)) begin
                            state_q  <= VERIFY;
                            fill_cnt <= '0;
                            good     <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + FW'(1);
                        end
                    end
                end
                VERIFY: begin
                    if (in_valid) begin
                        sr <= {sr[LFSR_W-2:0], in_bit};
                        if (match) begin
                            if (good == CW'(LOCK_COUNT - 1)) begin
                                state_q <= LOCKED;
                                locked  <= 1'b1;
                                good    <= '0;
                                bad     <= '0;
                            end else begin
                                good <= good + CW'(1);
                            end
                        end else begin
                            good <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (in_valid) begin
                        // Flywheel: a flipped received bit never corrupts the prediction.
                        sr <= {sr[LFSR_W-2:0], pred};
                        if (match) begin
                            bad <= '0;
                        end else if (bad == CW'(LOSS_THRESH - 1)) begin
                            state_q <= VERIFY;
                            locked  <= 1'b0;
                            bad     <= '0;
                            good    <= '0;
                        end else begin
                            bad <= bad + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= FILL;
                    sr       <= '0;
                    fill_cnt <= '0;
                    good     <= '0;
                    bad      <= '0;
                    locked   <= 1'b0;
                end
            endcase
        end
    end

endmodule
